id_ex_stage_reg: RTL and testbench

//  ID->EX pipeline register with valid/allowin handshake. Consumes the hazard unit's

---
 rtl/id_ex_stage_reg.sv | 87 ++++++++
 tb/tb_id_ex_stage_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with valid/allowin handshake, flush/bubble handling,
// back-pressure hold and saturating pipeline-efficiency event counters.
module id_ex_stage_reg #(
  parameter int DATA_W = 128,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_ready_go,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [DATA_W-1:0] id_payload,
  input  logic              ex_flush,
  input  logic              ex_ready_out,
  input  logic              cnt_clr,
  output logic              id_allowin,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_payload,
  output logic [CNT_W-1:0]  cnt_bubble,
  output logic [CNT_W-1:0]  cnt_kill,
  output logic [CNT_W-1:0]  cnt_bp
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   fire;
  logic   ev_bubble, ev_kill, ev_bp;

  assign ex_valid   = (state == FULL);
  assign id_allowin = !ex_flush && (!ex_valid || ex_ready_out);
  assign fire       = id_valid && id_ready_go && id_allowin;

  // NOTE: combinational blocks assign every output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (ex_flush)                      state_nxt = EMPTY;
    else if (fire)                     state_nxt = FULL;
    else if (ex_valid && ex_ready_out) state_nxt = EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // NOTE: the data registers are plain flops, not a memory, so clearing them on reset is cheap and keeps ex_pc/ex_payload deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_pc      <= '0;
      ex_payload <= '0;
    end else if (fire) begin
      ex_pc      <= id_pc;
      ex_payload <= id_payload;
    end
  end

  // A flush that both kills a stuck EX instruction and bubbles ID is counted as a kill only.
  assign ev_kill   = ex_flush && ex_valid && !ex_ready_out;
  assign ev_bubble = ex_flush && id_valid && !id_ready_go && !ev_kill;
  assign ev_bp     = ex_valid && !ex_ready_out && !ex_flush;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic en);
    if (cnt_clr)              return '0;
    if (en && (c != '1))      return c + CNT_W'(1);
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_bubble <= '0;
      cnt_kill   <= '0;
      cnt_bp     <= '0;
    end else begin
      cnt_bubble <= bump(cnt_bubble, ev_bubble);
      cnt_kill   <= bump(cnt_kill, ev_kill);
      cnt_bp     <= bump(cnt_bp, ev_bp);
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed vector table, hand-written
// saturation/reset sequences, then randomized traffic against a behavioural model.
module tb_id_ex_stage_reg;

  logic         clk = 1'b0;
  logic         rst;
  logic         id_valid, id_ready_go, ex_flush, ex_ready_out, cnt_clr;
  logic [31:0]  id_pc;
  logic [127:0] id_payload;

  logic         id_allowin, ex_valid;
  logic [31:0]  ex_pc;
  logic [127:0] ex_payload;
  logic [31:0]  cnt_bubble, cnt_kill, cnt_bp;

  logic         s_allowin, s_valid;
  logic [31:0]  s_pc;
  logic [127:0] s_payload;
  logic [3:0]   s_bubble, s_kill, s_bp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready_go(id_ready_go),
    .id_pc(id_pc), .id_payload(id_payload), .ex_flush(ex_flush),
    .ex_ready_out(ex_ready_out), .cnt_clr(cnt_clr), .id_allowin(id_allowin),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_payload(ex_payload),
    .cnt_bubble(cnt_bubble), .cnt_kill(cnt_kill), .cnt_bp(cnt_bp)
  );

  id_ex_stage_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready_go(id_ready_go),
    .id_pc(id_pc), .id_payload(id_payload), .ex_flush(ex_flush),
    .ex_ready_out(ex_ready_out), .cnt_clr(cnt_clr), .id_allowin(s_allowin),
    .ex_valid(s_valid), .ex_pc(s_pc), .ex_payload(s_payload),
    .cnt_bubble(s_bubble), .cnt_kill(s_kill), .cnt_bp(s_bp)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] payload_of(input logic [31:0] pc);
    return {pc ^ 32'hdeadbeef, ~pc, pc, pc + 32'h1234_5678};
  endfunction

  // Behavioural model: slot contents plus unbounded event counts since last clear.
  logic         m_valid;
  logic [31:0]  m_pc;
  logic [127:0] m_pl;
  int           n_bub, n_kill, n_bp;

  function automatic logic m_allow();
    return !ex_flush && (!m_valid || ex_ready_out);
  endfunction

  function automatic logic [3:0] sat4(input int n);
    return (n > 15) ? 4'd15 : 4'(n);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_pc = '0; m_pl = '0;
    n_bub = 0; n_kill = 0; n_bp = 0;
  endtask

  task automatic model_step();
    bit killed, bubbled, stuck, take;
    killed  = ex_flush && m_valid && !ex_ready_out;
    bubbled = ex_flush && id_valid && !id_ready_go && !killed;
    stuck   = m_valid && !ex_ready_out && !ex_flush;
    take    = id_valid && id_ready_go && m_allow();
    if (cnt_clr) begin
      n_bub = 0; n_kill = 0; n_bp = 0;
    end else begin
      n_bub  += int'(bubbled);
      n_kill += int'(killed);
      n_bp   += int'(stuck);
    end
    if (ex_flush)          m_valid = 1'b0;
    else if (take)         begin m_valid = 1'b1; m_pc = id_pc; m_pl = id_payload; end
    else if (ex_ready_out) m_valid = 1'b0;
  endtask

  task automatic apply(input logic v, go, fl, rdy, input logic [31:0] pc, input logic clr);
    id_valid = v; id_ready_go = go; ex_flush = fl; ex_ready_out = rdy;
    id_pc = pc; id_payload = payload_of(pc); cnt_clr = clr;
    #1;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic v, go, fl, rdy;
    logic [31:0] pc;
    logic e_allow, e_valid;
    logic [31:0] e_pc;
    int e_bub, e_kill, e_bp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          v  go fl rdy pc             allow valid e_pc          bub kill bp
    vecs[0]  = '{1, 1, 0, 1, 32'h1c000000, 1, 1, 32'h1c000000, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 1, 32'h1c000004, 1, 1, 32'h1c000004, 0, 0, 0};
    vecs[2]  = '{1, 1, 0, 1, 32'h1c000008, 1, 1, 32'h1c000008, 0, 0, 0};
    vecs[3]  = '{1, 0, 1, 1, 32'h1c000010, 0, 0, 32'h0,        1, 0, 0};
    vecs[4]  = '{1, 1, 0, 1, 32'h1c000010, 1, 1, 32'h1c000010, 1, 0, 0};
    vecs[5]  = '{1, 1, 0, 1, 32'h00000020, 1, 1, 32'h00000020, 1, 0, 0};
    vecs[6]  = '{1, 1, 0, 0, 32'h00000024, 0, 1, 32'h00000020, 1, 0, 1};
    vecs[7]  = '{1, 1, 0, 0, 32'h00000024, 0, 1, 32'h00000020, 1, 0, 2};
    vecs[8]  = '{1, 1, 0, 0, 32'h00000024, 0, 1, 32'h00000020, 1, 0, 3};
    vecs[9]  = '{0, 1, 1, 0, 32'h00000024, 0, 0, 32'h0,        1, 1, 3};
    vecs[10] = '{0, 1, 0, 0, 32'h00000000, 1, 0, 32'h0,        1, 1, 3};
    vecs[11] = '{1, 1, 0, 0, 32'h00000030, 1, 1, 32'h00000030, 1, 1, 3};
    vecs[12] = '{1, 0, 0, 1, 32'h00000034, 1, 0, 32'h0,        1, 1, 3};

    // Reset held while ID presents a valid instruction.
    rst = 1'b1;
    model_reset();
    apply(1, 1, 0, 1, 32'h1c00_0000, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_ex_pc", ex_pc, 32'h0);
    check("rst_counters", {cnt_bubble, cnt_kill, cnt_bp}, 96'h0);
    rst = 1'b0;

    // Directed vectors: streaming, load-use bubble, back-pressure, exception kill.
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].v, vecs[i].go, vecs[i].fl, vecs[i].rdy, vecs[i].pc, 0);
      check($sformatf("vec%0d_allowin", i), id_allowin, vecs[i].e_allow);
      step();
      check($sformatf("vec%0d_ex_valid", i), ex_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_ex_pc", i), ex_pc, vecs[i].e_pc);
        check($sformatf("vec%0d_payload", i), ex_payload, payload_of(vecs[i].e_pc));
      end
      check($sformatf("vec%0d_cnt_bubble", i), cnt_bubble, 32'(vecs[i].e_bub));
      check($sformatf("vec%0d_cnt_kill", i), cnt_kill, 32'(vecs[i].e_kill));
      check($sformatf("vec%0d_cnt_bp", i), cnt_bp, 32'(vecs[i].e_bp));
    end

    // Saturation: 20 back-pressure cycles on the 4-bit instance.
    apply(0, 0, 0, 0, 32'h0, 1);
    step();
    check("clr_all", {cnt_bubble, cnt_kill, cnt_bp}, 96'h0);
    apply(1, 1, 0, 1, 32'h20, 0);
    step();
    for (int i = 0; i < 20; i++) begin
      apply(1, 1, 0, 0, 32'h24, 0);
      step();
    end
    check("sat_cnt_bp4", s_bp, 4'd15);
    check("sat_cnt_bp32", cnt_bp, 32'd20);
    check("sat_hold_pc", s_pc, 32'h20);
    apply(1, 1, 0, 0, 32'h24, 1);
    step();
    check("clr_prio_bp4", s_bp, 4'd0);
    check("clr_prio_bp32", cnt_bp, 32'd0);

    // Asynchronous reset asserted mid-cycle while FULL.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", ex_valid, 1'b0);
    check("async_rst_pc", ex_pc, 32'h0);
    check("async_rst_payload", ex_payload, 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0,
            $urandom, $urandom_range(0, 63) == 0);
      check("rnd_allowin", id_allowin, m_allow());
      check("rnd_allowin_sat", s_allowin, m_allow());
      step();
      check("rnd_ex_valid", ex_valid, m_valid);
      if (m_valid) begin
        check("rnd_ex_pc", ex_pc, m_pc);
        check("rnd_payload", ex_payload, m_pl);
      end
      check("rnd_cnt_bubble", cnt_bubble, 32'(n_bub));
      check("rnd_cnt_kill", cnt_kill, 32'(n_kill));
      check("rnd_cnt_bp", cnt_bp, 32'(n_bp));
      check("rnd_sat_counters", {s_bubble, s_kill, s_bp}, {sat4(n_bub), sat4(n_kill), sat4(n_bp)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
